// File: rtl/rr_grant_consumer.sv
// rr_grant_consumer
//   Requestor-side front end for a 4-way round-robin bus arbiter. Each client
//   writes into its own 2-deep FIFO. A non-empty FIFO raises its req_vector
//   bit. A legal one-hot grant from the arbiter moves the head word of the
//   granted FIFO into a single output register with valid/ready handshake.
//
// Ports
//   CLK, RST       clock; synchronous active-high reset
//   in_valid[4]    per-client write strobe
//   in_data        client words, client i at [i*DATA_W +: DATA_W]
//   in_ready[4]    per-client FIFO not full (low while RST)
//   req_vector[4]  to arbiter: FIFO i non-empty
//   enable         to arbiter: output register can take a word this cycle
//   grant_vector   from arbiter: registered one-hot grant
//   bus_valid/bus_data/bus_src/bus_ready  shared output bus
//   grant_err      sticky: zero/multi-hot grant seen while requesting

// Per-client 2-entry FIFO. Storage carries no reset; only the pointers and
// the occupancy count do.
module rr_port_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);
  logic [1:0][DATA_W-1:0] mem;
  logic                   wr_ptr, rd_ptr;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      // Simultaneous push+pop keeps the count.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

module rr_grant_consumer #(
  parameter int DATA_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic [3:0]          req_vector,
  output logic                enable,
  input  logic [3:0]          grant_vector,
  output logic                bus_valid,
  output logic [DATA_W-1:0]   bus_data,
  output logic [1:0]          bus_src,
  input  logic                bus_ready,
  output logic                grant_err
);
  localparam int NUM_PORTS = 4;

  logic [NUM_PORTS-1:0][1:0]        cnt;
  logic [NUM_PORTS-1:0][DATA_W-1:0] head;
  logic [NUM_PORTS-1:0]             push, pop;
  logic                             free, onehot, illegal;
  logic [DATA_W-1:0]                xfer_data;
  logic [1:0]                       xfer_src;

  assign free    = !bus_valid || bus_ready;
  assign enable  = free && !RST;
  assign onehot  = (grant_vector != 4'b0) &&
                   ((grant_vector & (grant_vector - 4'd1)) == 4'b0);
  // Bad grants only matter when something is actually requesting.
  assign illegal = !onehot && (req_vector != 4'b0);

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign in_ready[g]   = (cnt[g] != 2'd2) && !RST;
    assign req_vector[g] = (cnt[g] != 2'd0);
    assign push[g]       = in_valid[g] && in_ready[g];
    // Stale grant to an empty FIFO simply yields no pop.
    assign pop[g]        = grant_vector[g] && onehot && (cnt[g] != 2'd0) && free;

    rr_port_fifo #(.DATA_W(DATA_W)) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata (in_data[g*DATA_W +: DATA_W]),
      .head  (head[g]),
      .count (cnt[g])
    );
  end

  // pop is one-hot or zero, so a priority loop is just a mux.
  always_comb begin
    xfer_data = '0;
    xfer_src  = 2'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (pop[i]) begin
        xfer_data = head[i];
        xfer_src  = 2'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus_valid <= 1'b0;
      bus_data  <= '0;
      bus_src   <= 2'd0;
      grant_err <= 1'b0;
    end else begin
      if (illegal) grant_err <= 1'b1;
      if (pop != 4'b0) begin
        bus_valid <= 1'b1;
        bus_data  <= xfer_data;
        bus_src   <= xfer_src;
      end else if (bus_ready) begin
        bus_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_grant_consumer.sv
module tb_rr_grant_consumer;
  localparam int DATA_W = 8;

  logic                CLK = 1'b0;
  logic                RST;
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_ready;
  logic [3:0]          req_vector;
  logic                enable;
  logic [3:0]          grant_vector;
  logic                bus_valid;
  logic [DATA_W-1:0]   bus_data;
  logic [1:0]          bus_src;
  logic                bus_ready;
  logic                grant_err;

  int checks   = 0;
  int failures = 0;

  rr_grant_consumer #(.DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .req_vector(req_vector), .enable(enable),
    .grant_vector(grant_vector), .bus_valid(bus_valid), .bus_data(bus_data),
    .bus_src(bus_src), .bus_ready(bus_ready), .grant_err(grant_err)
  );

  always #5 CLK = ~CLK;

  // Advance one edge; inputs set after this are sampled on the next edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_word(input int port, input logic [7:0] v);
    in_data[port*DATA_W +: DATA_W] = v;
  endtask

  task automatic test_reset();
    RST = 1'b1; in_valid = 4'b0; in_data = '0; grant_vector = 4'b0; bus_ready = 1'b1;
    step(); step();
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL rst_in_ready got=%b exp=0000", in_ready); end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rst_enable got=%b exp=0", enable); end
    checks++; if (bus_data !== 8'h00 || bus_src !== 2'd0) begin failures++; $display("FAIL rst_bus got=%h/%0d exp=00/0", bus_data, bus_src); end
    RST = 1'b0;
    step();
    checks++; if (in_ready !== 4'b1111) begin failures++; $display("FAIL idle_in_ready got=%b exp=1111", in_ready); end
    checks++; if (req_vector !== 4'b0000) begin failures++; $display("FAIL idle_req got=%b exp=0000", req_vector); end
    checks++; if (bus_valid !== 1'b0 || grant_err !== 1'b0 || enable !== 1'b1) begin failures++; $display("FAIL idle_out got=v%b e%b en%b exp=v0 e0 en1", bus_valid, grant_err, enable); end
    grant_vector = 4'b0001; step();
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL idle_grant_no_xfer got=%b exp=0", bus_valid); end
    grant_vector = 4'b0110; step();
    checks++; if (grant_err !== 1'b0) begin failures++; $display("FAIL idle_multihot_ignored got=%b exp=0", grant_err); end
    grant_vector = 4'b0001;
  endtask

  task automatic test_single();
    set_word(2, 8'hA5); in_valid = 4'b0100;
    step();  // edge t: push
    in_valid = 4'b0;
    checks++; if (req_vector !== 4'b0100 || bus_valid !== 1'b0) begin failures++; $display("FAIL single_req got=%b v%b exp=0100 v0", req_vector, bus_valid); end
    step();  // edge t+1: arbiter registers grant
    grant_vector = 4'b0100;
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL single_early got=%b exp=0", bus_valid); end
    step();  // edge t+2: transfer
    checks++; if (bus_valid !== 1'b1 || bus_data !== 8'hA5 || bus_src !== 2'd2) begin failures++; $display("FAIL single_xfer got=v%b %h/%0d exp=v1 a5/2", bus_valid, bus_data, bus_src); end
    checks++; if (req_vector !== 4'b0000) begin failures++; $display("FAIL single_req_drop got=%b exp=0000", req_vector); end
    step();  // stale grant, downstream took the word
    checks++; if (bus_valid !== 1'b0 || bus_data !== 8'hA5) begin failures++; $display("FAIL single_drain got=v%b %h exp=v0 a5", bus_valid, bus_data); end
  endtask

  task automatic test_fifo_full();
    grant_vector = 4'b0010;
    set_word(0, 8'h11); in_valid = 4'b0001; step();
    checks++; if (in_ready[0] !== 1'b1) begin failures++; $display("FAIL full_after1 got=%b exp=1", in_ready[0]); end
    set_word(0, 8'h22); step();
    checks++; if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL full_after2 got=%b exp=0", in_ready[0]); end
    set_word(0, 8'h33); step();
    in_valid = 4'b0;
    checks++; if (in_ready !== 4'b1110 || req_vector !== 4'b0001) begin failures++; $display("FAIL full_hold got=%b/%b exp=1110/0001", in_ready, req_vector); end
    grant_vector = 4'b0001; step();
    checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h11 || bus_src !== 2'd0 || in_ready[0] !== 1'b1) begin failures++; $display("FAIL full_w1 got=v%b %h/%0d r%b exp=v1 11/0 r1", bus_valid, bus_data, bus_src, in_ready[0]); end
    step();
    checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h22) begin failures++; $display("FAIL full_w2 got=v%b %h exp=v1 22", bus_valid, bus_data); end
    step();
    checks++; if (bus_valid !== 1'b0 || req_vector !== 4'b0000) begin failures++; $display("FAIL full_no_w3 got=v%b req=%b exp=v0 0000", bus_valid, req_vector); end
  endtask

  task automatic test_back_to_back();
    grant_vector = 4'b1000;
    set_word(1, 8'h41); in_valid = 4'b0010; step();
    grant_vector = 4'b0010; set_word(1, 8'h42); step();  // pop 41 + push 42
    checks++; if (bus_data !== 8'h41 || req_vector !== 4'b0010 || in_ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_w1 got=%h req=%b exp=41 0010", bus_data, req_vector); end
    set_word(1, 8'h43); step();
    in_valid = 4'b0;
    checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h42 || bus_src !== 2'd1) begin failures++; $display("FAIL b2b_w2 got=v%b %h/%0d exp=v1 42/1", bus_valid, bus_data, bus_src); end
    step();
    checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h43) begin failures++; $display("FAIL b2b_w3 got=v%b %h exp=v1 43", bus_valid, bus_data); end
    step();
    checks++; if (bus_valid !== 1'b0 || req_vector !== 4'b0000) begin failures++; $display("FAIL b2b_end got=v%b req=%b exp=v0 0000", bus_valid, req_vector); end
  endtask

  task automatic test_backpressure();
    grant_vector = 4'b0001;
    set_word(2, 8'h61); in_valid = 4'b0100; step();
    set_word(2, 8'h62); step();
    in_valid = 4'b0; bus_ready = 1'b0; grant_vector = 4'b0100; step();
    checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h61 || enable !== 1'b0) begin failures++; $display("FAIL bp_first got=v%b %h en%b exp=v1 61 en0", bus_valid, bus_data, enable); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus_valid !== 1'b1 || bus_data !== 8'h61 || bus_src !== 2'd2 || enable !== 1'b0 || req_vector !== 4'b0100 || in_ready[2] !== 1'b1) begin
        failures++; $display("FAIL bp_hold%0d got=v%b %h/%0d en%b req=%b exp=v1 61/2 en0 0100", k, bus_valid, bus_data, bus_src, enable, req_vector);
      end
    end
    bus_ready = 1'b1; #1;
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL bp_enable got=%b exp=1", enable); end
    step();
    checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h62 || req_vector !== 4'b0000) begin failures++; $display("FAIL bp_release got=v%b %h req=%b exp=v1 62 0000", bus_valid, bus_data, req_vector); end
    step();
    checks++; if (bus_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", bus_valid); end
  endtask

  task automatic test_illegal();
    grant_vector = 4'b1000;
    set_word(0, 8'h71); set_word(1, 8'h72); in_valid = 4'b0011; step();
    in_valid = 4'b0; grant_vector = 4'b0011; step();
    checks++; if (bus_valid !== 1'b0 || grant_err !== 1'b1 || req_vector !== 4'b0011) begin failures++; $display("FAIL ill_multihot got=v%b e%b req=%b exp=v0 e1 0011", bus_valid, grant_err, req_vector); end
    grant_vector = 4'b0001; step();
    checks++; if (bus_data !== 8'h71 || bus_src !== 2'd0 || grant_err !== 1'b1) begin failures++; $display("FAIL ill_resume0 got=%h/%0d e%b exp=71/0 e1", bus_data, bus_src, grant_err); end
    grant_vector = 4'b0010; step();
    checks++; if (bus_data !== 8'h72 || bus_src !== 2'd1 || grant_err !== 1'b1) begin failures++; $display("FAIL ill_resume1 got=%h/%0d e%b exp=72/1 e1", bus_data, bus_src, grant_err); end
    step();
  endtask

  task automatic test_stale_reset();
    RST = 1'b1; step(); RST = 1'b0; step();
    checks++; if (grant_err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", grant_err); end
    grant_vector = 4'b1000; bus_ready = 1'b0;
    set_word(0, 8'h80); set_word(1, 8'h81); set_word(2, 8'h82); set_word(3, 8'h83);
    in_valid = 4'b0111; step(); step();
    checks++; if (bus_valid !== 1'b0 || grant_err !== 1'b0 || req_vector !== 4'b0111) begin failures++; $display("FAIL stale_grant got=v%b e%b req=%b exp=v0 e0 0111", bus_valid, grant_err, req_vector); end
    in_valid = 4'b1000; step(); step(); step();
    in_valid = 4'b0;
    checks++; if (bus_valid !== 1'b1 || bus_data !== 8'h83 || bus_src !== 2'd3) begin failures++; $display("FAIL stale_p3 got=v%b %h/%0d exp=v1 83/3", bus_valid, bus_data, bus_src); end
    checks++; if (req_vector !== 4'b1111 || in_ready !== 4'b0000) begin failures++; $display("FAIL all_full got=%b/%b exp=1111/0000", req_vector, in_ready); end
    RST = 1'b1; step();
    checks++; if (bus_valid !== 1'b0 || req_vector !== 4'b0000 || enable !== 1'b0) begin failures++; $display("FAIL midrst got=v%b req=%b en%b exp=v0 0000 en0", bus_valid, req_vector, enable); end
    RST = 1'b0; bus_ready = 1'b1; step();
    checks++; if (in_ready !== 4'b1111 || bus_valid !== 1'b0) begin failures++; $display("FAIL after_rst got=%b v%b exp=1111 v0", in_ready, bus_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fifo_full();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_stale_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
